bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly downstream of the binary counter.
- It samples the counter's count value and produces packed BCD digits for the 7-segment/display stage.
- Converts one bit per clock to keep logic small. A valid/ready handshake on input and a one-cycle done pulse on output.

---
 rtl/bin2bcd_seq.sv | 121 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional build macro BIN2BCD_BLANK_EN: leading-zero digits above units are loaded as 4'hF.
//
// state | meaning
// IDLE  | ready for a new value; in_ready high
// SHIFT | add-3 then shift once per clock; final clock copies the BCD field out
// DONE  | result just loaded into bcd; out_valid high for one cycle
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      bin,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid
);

    localparam int SW = 4*DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH+1);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint MAXV = (longint'(1) << WIDTH) - 1;

    generate
        if (pow10(DIGITS) <= MAXV) begin : g_digits_too_few
            $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [SW-1:0]       sreg, sreg_nxt, sreg_adj;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [4*DIGITS-1:0] bcd_q, bcd_nxt, bcd_fmt;
`ifdef BIN2BCD_BLANK_EN
    logic                lead;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            bcd_q <= bcd_nxt;
        end
    end

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        sreg_adj = sreg;
        for (int d = 0; d < DIGITS; d++) begin
            if (sreg[WIDTH+4*d +: 4] >= 4'd5)
                sreg_adj[WIDTH+4*d +: 4] = sreg[WIDTH+4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        bcd_fmt = sreg[SW-1:WIDTH];
`ifdef BIN2BCD_BLANK_EN
        lead = 1'b1;
        for (int d = DIGITS-1; d >= 1; d--) begin
            if (lead && (bcd_fmt[4*d +: 4] == 4'd0))
                bcd_fmt[4*d +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        bcd_nxt   = bcd_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sreg_nxt  = {{(4*DIGITS){1'b0}}, bin};
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // cnt reaching WIDTH means all bits are in; this clock only publishes.
                if (cnt == CW'(WIDTH)) begin
                    bcd_nxt   = bcd_fmt;
                    state_nxt = DONE;
                end else begin
                    sreg_nxt = sreg_adj << 1;
                    cnt_nxt  = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: vector table, handshake corner sequences, random values
// against a decimal reference model, and a free-running counter feeding the input.
module tb_bin2bcd_seq;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = WIDTH + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  bin, bin_drv, ctr, ctr_seed;
    logic        chain, ctr_load;
    logic        in_ready, out_valid;
    logic [11:0] bcd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] e;
    } vec_t;
    vec_t tbl[6];

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .bin(bin),
        .in_ready(in_ready), .bcd(bcd), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    assign bin = chain ? ctr : bin_drv;

    always @(posedge clk) begin
        if (ctr_load) ctr <= ctr_seed;
        else          ctr <= ctr + 8'd1;
    end

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
`ifdef BIN2BCD_BLANK_EN
            if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!in_ready && k < 40) begin tick(); k++; end
        if (!in_ready) timeout({name, " ready"});
    endtask

    task automatic quiet_window(input string name, input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (out_valid) seen = 1;
            tick();
        end
        check({name, " no_out_valid"}, 32'(seen), 0);
    endtask

    task automatic run_conv(input logic [7:0] b, input logic [11:0] exp, input string name);
        int k;
        bit ok;
        logic [11:0] prev;
        wait_ready(name);
        in_valid = 1'b1;
        bin_drv  = b;
        prev     = bcd;
        tick();
        in_valid = 1'b0;
        bin_drv  = 8'($urandom);
        k  = 0;
        ok = 1;
        while (!out_valid && k < 30) begin
            if (bcd !== prev || in_ready) ok = 0;
            tick();
            k++;
        end
        if (!out_valid) timeout({name, " out_valid"});
        check({name, " latency"}, 32'(k), 32'(LAT));
        check({name, " bcd"}, 32'(bcd), 32'(exp));
        check({name, " quiet_during_shift"}, 32'(ok), 1);
        tick();
        check({name, " pulse_end"}, 32'(out_valid), 0);
        check({name, " ready_again"}, 32'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0]  sampled;
        logic [11:0] prev_res;

`ifdef BIN2BCD_BLANK_EN
        tbl[0] = '{8'd0,   12'hFF0};
        tbl[1] = '{8'd255, 12'h255};
        tbl[2] = '{8'd99,  12'hF99};
        tbl[3] = '{8'd128, 12'h128};
        tbl[4] = '{8'd7,   12'hFF7};
        tbl[5] = '{8'd40,  12'hF40};
`else
        tbl[0] = '{8'd0,   12'h000};
        tbl[1] = '{8'd255, 12'h255};
        tbl[2] = '{8'd99,  12'h099};
        tbl[3] = '{8'd128, 12'h128};
        tbl[4] = '{8'd7,   12'h007};
        tbl[5] = '{8'd40,  12'h040};
`endif

        rst = 1'b1; in_valid = 1'b0; bin_drv = 8'd0; chain = 1'b0;
        ctr_load = 1'b1; ctr_seed = 8'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset in_ready", 32'(in_ready), 1);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset bcd", 32'(bcd), 0);

        for (int i = 0; i < 6; i++)
            run_conv(tbl[i].b, tbl[i].e, $sformatf("table%0d", i));

        // Request arriving mid-conversion must be dropped.
        wait_ready("overlap");
        in_valid = 1'b1; bin_drv = 8'd37;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 30) begin
            if (k == 2) begin in_valid = 1'b1; bin_drv = 8'd200; end
            if (k == 3) in_valid = 1'b0;
            tick();
            k++;
        end
        in_valid = 1'b0;
        check("overlap latency", 32'(k), 32'(LAT));
        check("overlap bcd", 32'(bcd), 32'(ref_bcd(37)));
        tick();
        check("overlap ready_again", 32'(in_ready), 1);
        quiet_window("overlap dropped", 15);
        check("overlap bcd_held", 32'(bcd), 32'(ref_bcd(37)));

        // Reset in the middle of a conversion.
        wait_ready("midreset");
        in_valid = 1'b1; bin_drv = 8'd150;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset in_ready", 32'(in_ready), 1);
        check("midreset bcd", 32'(bcd), 0);
        check("midreset out_valid", 32'(out_valid), 0);
        quiet_window("midreset", 15);

        // Reset and request together: reset wins.
        run_conv(8'd123, ref_bcd(123), "pre_simul");
        rst = 1'b1; in_valid = 1'b1; bin_drv = 8'd77;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("simul in_ready", 32'(in_ready), 1);
        check("simul bcd", 32'(bcd), 0);
        quiet_window("simul", 15);

        run_conv(8'd255, ref_bcd(255), "wrap_hi");
        run_conv(8'd0,   ref_bcd(0),   "wrap_lo");

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            run_conv(b, ref_bcd(int'(b)), $sformatf("rand%0d", i));
        end

        // Counter chain: continuous requests, seeded so the samples cross 255->0.
        ctr_seed = 8'd230; ctr_load = 1'b1;
        tick();
        ctr_load = 1'b0;
        chain = 1'b1;
        in_valid = 1'b1;
        prev_res = bcd;
        for (int i = 0; i < 8; i++) begin
            wait_ready($sformatf("chain%0d", i));
            sampled = ctr;
            tick();
            k = 0;
            while (!out_valid && k < 30) begin tick(); k++; end
            if (!out_valid) timeout($sformatf("chain%0d out_valid", i));
            check($sformatf("chain%0d bcd", i), 32'(bcd), 32'(ref_bcd(int'(sampled))));
            tick();
        end
        in_valid = 1'b0;
        chain = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
